// File: rtl/rx_ring_fifo_if.sv
// Write/read bus of the frame-committing RX ring FIFO.
// The master drives write words and read requests; the slave is the FIFO.
interface rx_ring_fifo_if #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYTE_SIZE  = 8
);
  localparam int unsigned BeWidth = DATA_WIDTH / BYTE_SIZE;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BeWidth-1:0]    wr_byte_en;
  logic                  wr_last;
  logic                  wr_drop;
  logic                  wr_full;
  logic                  ovf_drop;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_valid;
  logic                  empty;
  logic [ADDR_WIDTH:0]   level;

  modport master (
    output wr_en, wr_data, wr_byte_en, wr_last, wr_drop, rd_en,
    input  wr_full, ovf_drop, rd_data, rd_last, rd_valid, empty, level
  );

  modport slave (
    input  wr_en, wr_data, wr_byte_en, wr_last, wr_drop, rd_en,
    output wr_full, ovf_drop, rd_data, rd_last, rd_valid, empty, level
  );
endinterface

// File: rtl/rx_ring_fifo.sv
// Ring FIFO that stores frames speculatively and exposes them to the reader only on commit
// (wr_last); uncommitted frames are dropped on wr_drop or on overflow.
module rx_ring_fifo #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYTE_SIZE  = 8
) (
  input logic           clk,
  input logic           rst,
  rx_ring_fifo_if.slave io_bus
);
  localparam int unsigned BeWidth  = DATA_WIDTH / BYTE_SIZE;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StFrame, StDiscard} wr_state_e;

  logic [DATA_WIDTH-1:0] r_mem      [Depth];
  logic                  r_last_mem [Depth];

  wr_state_e             r_state, w_state_d;
  logic [PtrWidth-1:0]   r_wr_ptr, w_wr_ptr_d;
  logic [PtrWidth-1:0]   r_cmt_ptr, w_cmt_ptr_d;
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [PtrWidth-1:0]   w_used;
  logic                  w_full, w_empty, w_we, w_re, w_ovf_d;
  logic                  r_ovf_drop, r_rd_valid, r_rd_last;
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Full counts pending words too, so a frame can never overrun unread data.
  assign w_used  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_used == PtrWidth'(Depth));
  assign w_empty = (r_cmt_ptr == r_rd_ptr);
  assign w_re    = io_bus.rd_en & ~w_empty;

  always_comb begin
    w_state_d   = r_state;
    w_wr_ptr_d  = r_wr_ptr;
    w_cmt_ptr_d = r_cmt_ptr;
    w_we        = 1'b0;
    w_ovf_d     = 1'b0;
    if (io_bus.wr_drop) begin
      w_wr_ptr_d = r_cmt_ptr;
      w_state_d  = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StFrame: begin
          if (io_bus.wr_en && !w_full) begin
            w_we       = 1'b1;
            w_wr_ptr_d = r_wr_ptr + PtrWidth'(1);
            if (io_bus.wr_last) begin
              w_cmt_ptr_d = r_wr_ptr + PtrWidth'(1);
              w_state_d   = StIdle;
            end else begin
              w_state_d = StFrame;
            end
          end else if (io_bus.wr_en) begin
            if (io_bus.wr_last) begin
              w_wr_ptr_d = r_cmt_ptr;
              w_ovf_d    = 1'b1;
              w_state_d  = StIdle;
            end else begin
              w_state_d = StDiscard;
            end
          end
        end
        StDiscard: begin
          if (io_bus.wr_en && io_bus.wr_last) begin
            w_wr_ptr_d = r_cmt_ptr;
            w_ovf_d    = 1'b1;
            w_state_d  = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_ovf_drop <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wr_ptr   <= w_wr_ptr_d;
      r_cmt_ptr  <= w_cmt_ptr_d;
      r_ovf_drop <= w_ovf_d;
      r_rd_valid <= w_re;
      if (w_re) begin
        r_rd_ptr  <= r_rd_ptr + PtrWidth'(1);
        r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        r_rd_last <= r_last_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  // Storage is deliberately not reset; disabled byte lanes keep their old contents.
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      for (int unsigned i = 0; i < BeWidth; i++) begin
        if (io_bus.wr_byte_en[i]) begin
          r_mem[r_wr_ptr[ADDR_WIDTH-1:0]][i*BYTE_SIZE +: BYTE_SIZE] <=
            io_bus.wr_data[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
      r_last_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= io_bus.wr_last;
    end
  end

  assign io_bus.wr_full  = w_full;
  assign io_bus.ovf_drop = r_ovf_drop;
  assign io_bus.rd_data  = r_rd_data;
  assign io_bus.rd_last  = r_rd_last;
  assign io_bus.rd_valid = r_rd_valid;
  assign io_bus.empty    = w_empty;
  assign io_bus.level    = r_cmt_ptr - r_rd_ptr;
endmodule

// File: tb/tb_rx_ring_fifo.sv
// Scoreboard bench for rx_ring_fifo: committed words are queued when written and
// compared against rd_data/rd_last whenever rd_valid appears.
module tb_rx_ring_fifo;
  localparam int unsigned DW = 48;
  localparam int unsigned AW = 5;
  localparam int unsigned BS = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [DW:0] sb[$];
  logic [DW:0] m_exp;

  rx_ring_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_SIZE(BS)) bus ();

  rx_ring_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_SIZE(BS)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are observed on the falling edge only.
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got rd_data=%h rd_last=%b with nothing expected",
                 bus.rd_data, bus.rd_last);
      end else begin
        m_exp = sb.pop_front();
        if ({bus.rd_last, bus.rd_data} !== m_exp) begin
          errors++;
          $display("FAIL sb_data got last=%b data=%h exp last=%b data=%h",
                   bus.rd_last, bus.rd_data, m_exp[DW], m_exp[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.wr_byte_en = '1;
    bus.wr_last    = 1'b0;
    bus.wr_drop    = 1'b0;
    bus.rd_en      = 1'b0;
  endtask

  task automatic drv_wr(input logic [DW-1:0] d, input logic [5:0] be, input logic last);
    bus.wr_en      = 1'b1;
    bus.wr_data    = d;
    bus.wr_byte_en = be;
    bus.wr_last    = last;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", bus.empty); end
    checks++;
    if (bus.wr_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", bus.wr_full); end
    checks++;
    if (bus.level !== 6'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", bus.level); end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.ovf_drop !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got valid=%b ovf=%b exp 0 0", bus.rd_valid, bus.ovf_drop);
    end
    checks++;
    if ({bus.rd_last, bus.rd_data} !== 49'd0) begin
      errors++;
      $display("FAIL rst_rdata got %b/%h exp 0/0", bus.rd_last, bus.rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 48'hFFFF_FFFF_FFFF - 48'(i);
      drv_wr(d, 6'h3F, i == 3);
      sb.push_back({(i == 3), d});
      tick();
      checks++;
      if (bus.empty !== (i < 3)) begin
        errors++;
        $display("FAIL frame_empty word %0d got %b exp %b", i, bus.empty, (i < 3));
      end
    end
    idle();
    checks++;
    if (bus.level !== 6'd4) begin errors++; $display("FAIL frame_level got %0d exp 4", bus.level); end
    for (int i = 0; i < 4; i++) begin
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      checks++;
      if (bus.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL frame_rvalid read %0d got %b exp 1", i, bus.rd_valid);
      end
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL frame_rvalid_gap read %0d got %b exp 0", i, bus.rd_valid);
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.level !== 6'd0) begin
      errors++;
      $display("FAIL frame_drained got empty=%b level=%0d exp 1 0", bus.empty, bus.level);
    end
  endtask

  task automatic test_drop();
    logic [DW-1:0] d;
    for (int i = 0; i < 3; i++) begin
      drv_wr(rnd48(), 6'h3F, 1'b0);
      tick();
    end
    // wr_last alongside wr_drop must not commit anything.
    drv_wr(rnd48(), 6'h3F, 1'b1);
    bus.wr_drop = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.level !== 6'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL drop_level got level=%0d empty=%b exp 0 1", bus.level, bus.empty);
    end
    checks++;
    if (bus.ovf_drop !== 1'b0) begin errors++; $display("FAIL drop_ovf got %b exp 0", bus.ovf_drop); end
    tick();
    checks++;
    if (bus.ovf_drop !== 1'b0) begin errors++; $display("FAIL drop_ovf2 got %b exp 0", bus.ovf_drop); end
    for (int i = 0; i < 2; i++) begin
      d = rnd48();
      drv_wr(d, 6'h3F, i == 1);
      sb.push_back({(i == 1), d});
      tick();
    end
    idle();
    checks++;
    if (bus.level !== 6'd2) begin errors++; $display("FAIL drop_refill got %0d exp 2", bus.level); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL drop_rvalid read %0d got %b exp 1", i, bus.rd_valid);
      end
    end
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL drop_read_empty got valid=%b empty=%b exp 0 1", bus.rd_valid, bus.empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 40; i++) begin
      drv_wr(48'(i), 6'h3F, i == 40);
      tick();
      checks++;
      if (bus.wr_full !== (i >= 32 && i < 40)) begin
        errors++;
        $display("FAIL ovf_full word %0d got %b exp %b", i, bus.wr_full, (i >= 32 && i < 40));
      end
      checks++;
      if (bus.ovf_drop !== (i == 40)) begin
        errors++;
        $display("FAIL ovf_pulse word %0d got %b exp %b", i, bus.ovf_drop, (i == 40));
      end
    end
    idle();
    tick();
    checks++;
    if (bus.ovf_drop !== 1'b0 || bus.level !== 6'd0 || bus.wr_full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after got ovf=%b level=%0d full=%b exp 0 0 0",
               bus.ovf_drop, bus.level, bus.wr_full);
    end
  endtask

  task automatic test_byte_en();
    logic [DW-1:0] d;
    drv_wr(48'h0, 6'h3F, 1'b1);
    sb.push_back({1'b1, 48'h0});
    tick();
    idle();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    // Fill the remaining 31 slots so the next write lands on the zeroed slot again.
    for (int i = 0; i < 31; i++) begin
      d = rnd48();
      drv_wr(d, 6'h3F, i == 30);
      sb.push_back({(i == 30), d});
      tick();
    end
    idle();
    bus.rd_en = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL be_drain got empty=%b exp 1", bus.empty); end
    drv_wr(48'hFFFF_FFFF_FFFF, 6'b000011, 1'b1);
    sb.push_back({1'b1, 48'h0000_0000_FFFF});
    tick();
    idle();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL be_rvalid got %b exp 1", bus.rd_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    for (int i = 0; i < 32; i++) begin
      d = rnd48();
      drv_wr(d, 6'h3F, i == 31);
      sb.push_back({(i == 31), d});
      tick();
    end
    idle();
    checks++;
    if (bus.wr_full !== 1'b1 || bus.level !== 6'd32) begin
      errors++;
      $display("FAIL b2b_fill got full=%b level=%0d exp 1 32", bus.wr_full, bus.level);
    end
    bus.rd_en = 1'b1;
    tick();
    for (int c = 0; c < 100; c++) begin
      d = rnd48();
      drv_wr(d, 6'h3F, 1'b1);
      sb.push_back({1'b1, d});
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.ovf_drop !== 1'b0 || bus.wr_full !== 1'b0) begin
        errors++;
        $display("FAIL b2b_cycle %0d got valid=%b ovf=%b full=%b exp 1 0 0",
                 c, bus.rd_valid, bus.ovf_drop, bus.wr_full);
      end
    end
    idle();
    bus.rd_en = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_drain read %0d got %b exp 1", i, bus.rd_valid);
      end
    end
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got valid=%b empty=%b exp 0 1", bus.rd_valid, bus.empty);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    for (int i = 0; i < 7; i++) begin
      drv_wr(rnd48(), 6'h3F, i == 4);
      tick();
    end
    checks++;
    if (bus.level !== 6'd5) begin errors++; $display("FAIL rmid_level got %0d exp 5", bus.level); end
    // Reset must beat a concurrent commit and a concurrent read.
    drv_wr(rnd48(), 6'h3F, 1'b1);
    bus.rd_en = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (bus.empty !== 1'b1 || bus.level !== 6'd0) begin
      errors++;
      $display("FAIL rmid_empty got empty=%b level=%0d exp 1 0", bus.empty, bus.level);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.ovf_drop !== 1'b0) begin
      errors++;
      $display("FAIL rmid_flags got valid=%b ovf=%b exp 0 0", bus.rd_valid, bus.ovf_drop);
    end
    tick();
    checks++;
    if (bus.ovf_drop !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b exp 0", bus.ovf_drop); end
    d = rnd48();
    drv_wr(d, 6'h3F, 1'b1);
    sb.push_back({1'b1, d});
    tick();
    idle();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rmid_read got %b exp 1", bus.rd_valid); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_frame();
    test_drop();
    test_overflow();
    test_byte_en();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_ring_fifo.md
RX_RING_FIFO -- requirements
Module: rx_ring_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 48, payload word width; SHALL be a multiple of BYTE_SIZE.
REQ-002 Parameter ADDR_WIDTH, default 5, log2 of ring depth; depth = 2**ADDR_WIDTH words.
REQ-003 Parameter BYTE_SIZE, default 8, bits per byte-enable lane; BE_WIDTH = DATA_WIDTH/BYTE_SIZE.
REQ-004 Single clock, synchronous active-high reset; ports named clk and rst.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 wr_en  in  1  write request for one word.
REQ-008 wr_data  in  DATA_WIDTH  write word.
REQ-009 wr_byte_en  in  BE_WIDTH  per-lane write enable; bit i covers bits [i*BYTE_SIZE +: BYTE_SIZE].
REQ-010 wr_last  in  1  qualifies wr_en; marks last word of frame (commit).
REQ-011 wr_drop  in  1  discard the uncommitted frame.
REQ-012 wr_full  out  1  ring holds 2**ADDR_WIDTH written (committed + pending) words.
REQ-013 ovf_drop  out  1  one-cycle pulse: frame discarded due to overflow.
REQ-014 rd_en  in  1  read request.
REQ-015 rd_data  out  DATA_WIDTH  read word.
REQ-016 rd_last  out  1  stored frame-end flag of rd_data.
REQ-017 rd_valid  out  1  rd_data/rd_last valid this cycle.
REQ-018 empty  out  1  no committed unread words.
REQ-019 level  out  ADDR_WIDTH+1  committed unread word count.

Function
REQ-020 Pointers wr_ptr (speculative), cmt_ptr (committed), rd_ptr, each ADDR_WIDTH+1 bits, wrap modulo 2**(ADDR_WIDTH+1); RAM index = low ADDR_WIDTH bits.
REQ-021 Storage per entry: DATA_WIDTH data + 1 last flag; last flag written whenever any write is accepted.
REQ-022 Byte lanes with wr_byte_en=0 SHALL retain prior RAM contents; data in RAM is never cleared by reset.
REQ-023 wr_full = (wr_ptr - rd_ptr) == 2**ADDR_WIDTH; empty = (cmt_ptr == rd_ptr); level = cmt_ptr - rd_ptr; all from registered pointers.
REQ-024 Write FSM states IDLE, FRAME, DISCARD; reset state IDLE.
REQ-025 IDLE/FRAME, wr_en & !wr_full & !wr_drop: write at wr_ptr, wr_ptr+1; if wr_last, cmt_ptr <= wr_ptr+1, go IDLE, else go FRAME.
REQ-026 IDLE/FRAME, wr_en & wr_full & !wr_drop: no write; if wr_last, wr_ptr <= cmt_ptr, ovf_drop=1, IDLE; else go DISCARD.
REQ-027 DISCARD: all writes ignored; wr_en & wr_last -> wr_ptr <= cmt_ptr, ovf_drop=1 next cycle, IDLE.
REQ-028 wr_drop in any state: wr_ptr <= cmt_ptr, go IDLE, ovf_drop stays 0; simultaneous wr_en is ignored (drop wins).
REQ-029 Read: rd_en & !empty -> rd_ptr+1; rd_data/rd_last from RAM[rd_ptr] with rd_valid=1 exactly one cycle later.
REQ-030 rd_en & empty: no pointer change; rd_valid=0 next cycle; rd_data holds last value.
REQ-031 Commit and read in same cycle: read uses pre-commit empty; newly committed words readable from next cycle.
REQ-032 Read and write same cycle: both proceed; wr_full recomputed from updated pointers next cycle.
REQ-033 Read-during-write to same address cannot occur (only committed entries read).
REQ-034 Latency: accepted final word to empty=0 is 1 cycle; rd_en to rd_valid is 1 cycle.

Reset
REQ-035 rst SHALL set wr_ptr, cmt_ptr, rd_ptr to 0, FSM IDLE, rd_valid=0, ovf_drop=0, rd_data=0, rd_last=0; outputs: empty=1, wr_full=0, level=0.
REQ-036 rst mid-frame SHALL discard pending and committed content without ovf_drop pulse; rst overrides all inputs same edge.

Verification
REQ-037 Reset, write 4 words 0xFFFF_FFFF_FFFF..0xFFFF_FFFF_FFFC, wr_last on 4th -> empty=1 until cycle after 4th write, then level=4; 4 reads -> same data in order, rd_last=1 on 4th only, rd_valid 1 cycle after each rd_en.
REQ-038 Write 3 words no wr_last, then wr_drop -> level stays 0, empty=1, wr_ptr back to cmt_ptr; next 2-word frame reads back correctly.
REQ-039 Write 40-word frame into empty depth-32 ring -> wr_full=1 after word 32, DISCARD entered, ovf_drop=1 one cycle after word 40 (wr_last), level=0, wr_full=0.
REQ-040 Write word 0x0000_0000_0000, then rewrite same slot with 0xFFFF_FFFF_FFFF and wr_byte_en=6'b000011 after read-out and ring wrap -> read returns 0x0000_0000_FFFF.
REQ-041 Commit 32 words, read continuously while writing new 1-word frames every cycle for 100 cycles -> pointer wrap, no data loss, no ovf_drop, order preserved.
REQ-042 Assert rst while FSM in FRAME with level=5 -> next cycle empty=1, level=0, rd_valid=0, ovf_drop=0.
